store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered stores (power of two, at least 2).
REQ-002 Parameter: AW, default 7, data-memory word-address width.
REQ-003 Parameter: DW, default 32, data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 st_valid  input  1  store request from the execute stage.
REQ-007 st_addr  input  AW  store word address.
REQ-008 st_data  input  DW  store data.
REQ-009 st_ready  output  1  buffer accepts a store this cycle.
REQ-010 ld_valid  input  1  load request from the execute stage.
REQ-011 ld_addr  input  AW  load word address.
REQ-012 ld_hit  output  1  load address matches a buffered store.
REQ-013 ld_fwd_data  output  DW  forwarded data; valid when ld_hit=1.
REQ-014 ld_stall  output  1  load cannot use the memory port this cycle.
REQ-015 dm_addr  output  AW  address to the data memory.
REQ-016 dm_wren  output  1  write enable to the data memory.
REQ-017 dm_din  output  DW  write data to the data memory.
REQ-018 empty  output  1  no stores buffered.
REQ-019 count  output  $clog2(DEPTH)+1  number of buffered stores.

Function
REQ-020 Circular FIFO: head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-021 st_ready = (count != DEPTH), from registered state only; push occurs when st_valid && st_ready.
REQ-022 A full buffer accepts no push, even in a cycle where it drains.
REQ-023 Memory port arbitration: with count==DEPTH, drain wins and ld_stall=1; otherwise with ld_valid=1, the load wins.
REQ-024 When the load wins: dm_addr=ld_addr, dm_wren=0, ld_stall=0.
REQ-025 Drain when the load does not win and count>0: dm_addr/dm_din = head entry, dm_wren=1; head advances at that clock edge.
REQ-026 Idle (no load, empty): dm_wren=0, dm_addr=0, dm_din=0.
REQ-027 Simultaneous push and drain: count unchanged; both pointers advance.
REQ-028 Forwarding is combinational: ld_hit=1 iff ld_valid and any buffered entry matches ld_addr.
REQ-029 On multiple matches, ld_fwd_data is taken from the youngest entry (closest to tail).
REQ-030 A store pushed in the same cycle is not visible to forwarding until the next cycle.
REQ-031 The entry being drained in the current cycle remains eligible for forwarding in that cycle.
REQ-032 ld_fwd_data=0 when ld_hit=0.
REQ-033 Stores drain in strict program (push) order; no coalescing.
REQ-034 empty = (count==0).
REQ-035 Latency: a store accepted at edge N is written to memory no earlier than cycle N+1.

Reset
REQ-036 While reset=1 at a clock edge: head=tail=0, count=0, and all entry valid bits cleared.
REQ-037 Buffered stores are discarded on reset, including mid-drain; no dm_wren pulse is issued in the cycle after reset.
REQ-038 Post-reset outputs: st_ready=1, empty=1, dm_wren=0, ld_hit=0, ld_stall=0.

Structure
REQ-039 Shared package holds AW, DW, DEPTH defaults and the entry record type (addr, data).
REQ-040 Youngest-match lookup is one sub-module, store_buffer_match, which is purely combinational (entries, head, count, ld_addr -> hit, data).
REQ-041 FIFO pointers and arbitration reside in store_buffer.

Verification
REQ-042 Reset, then push (addr 5, data 20) with no loads -> next cycle dm_wren=1, dm_addr=5, dm_din=20; following cycle empty=1.
REQ-043 Push (7,15), then (7,30); load addr 7 while both are buffered -> ld_hit=1, ld_fwd_data=30; memory receives 15 then 30.
REQ-044 Hold ld_valid=1 (addr 3) every cycle and push 4 stores -> no drain until count=4; then ld_stall=1, dm_wren=1, count drops to 3.
REQ-045 With count=4, st_valid=1 -> st_ready=0 and the store is not accepted; after one drain, st_ready=1.
REQ-046 Push 3 stores, assert reset during the first drain -> count=0, empty=1, dm_wren=0 on the next cycle; no further writes.
REQ-047 Push 6 stores (addresses 1..6) with interleaved drains -> pointers wrap; memory writes occur in order 1..6.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared defaults and the buffered-store record for the store buffer.
// The entry record fixes the address/data widths, so AW/DW overrides must match these.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 7;
    localparam int unsigned SB_DW    = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Execute-stage / data-memory signal bundle of the store buffer.
// The master modport is the execute stage and memory; the slave modport is the buffer.
interface store_buffer_if #(
    parameter int unsigned DEPTH = store_buffer_pkg::SB_DEPTH,
    parameter int unsigned AW    = store_buffer_pkg::SB_AW,
    parameter int unsigned DW    = store_buffer_pkg::SB_DW
) ();

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_fwd_data;
    logic          ld_stall;
    logic [AW-1:0] dm_addr;
    logic          dm_wren;
    logic [DW-1:0] dm_din;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_fwd_data, ld_stall, dm_addr, dm_wren, dm_din, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_fwd_data, ld_stall, dm_addr, dm_wren, dm_din, empty, count
    );

endinterface

// File: rtl/store_buffer_match.sv
// Combinational youngest-match lookup over the occupied part of the store FIFO.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PW-1:0]    head,
    input  logic [CW-1:0]    count,
    input  logic [AW-1:0]    ld_addr,
    output logic             hit,
    output logic [DW-1:0]    data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && valid[idx] && (entries[idx].addr == ld_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores sharing one data-memory port with loads,
// with youngest-entry store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic          full;
    logic          load_win;
    logic          push;
    logic          drain;
    logic          match_hit;
    logic [DW-1:0] match_data;

    // A full buffer refuses pushes even while draining, so st_ready is purely registered.
    assign full     = (count_q == CW'(DEPTH));
    assign load_win = bus.ld_valid && !full;
    assign push     = bus.st_valid && !full;
    assign drain    = !load_win && (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                entries_q[tail_q] <= '{addr: bus.st_addr, data: bus.st_data};
                valid_q[tail_q]   <= 1'b1;
                tail_q            <= tail_q + 1'b1;
            end
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            unique case ({push, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .entries (entries_q),
        .valid   (valid_q),
        .head    (head_q),
        .count   (count_q),
        .ld_addr (bus.ld_addr),
        .hit     (match_hit),
        .data    (match_data)
    );

    always_comb begin
        bus.dm_addr = '0;
        bus.dm_din  = '0;
        bus.dm_wren = 1'b0;
        if (load_win) begin
            bus.dm_addr = bus.ld_addr;
        end else if (drain) begin
            bus.dm_addr = entries_q[head_q].addr;
            bus.dm_din  = entries_q[head_q].data;
            bus.dm_wren = 1'b1;
        end
    end

    assign bus.st_ready    = !full;
    assign bus.ld_stall    = full;
    assign bus.ld_hit      = bus.ld_valid && match_hit;
    assign bus.ld_fwd_data = bus.ld_hit ? match_data : '0;
    assign bus.empty       = (count_q == '0);
    assign bus.count       = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ment_t;

    logic clk = 1'b0;
    logic reset;
    bit   running = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ment_t         q[$];
    logic [AW-1:0] wq[$];

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask

    task automatic set_ld(input logic v, input logic [AW-1:0] a);
        bus.ld_valid = v;
        bus.ld_addr  = a;
    endtask

    // Reference state update: memory port goes to the load unless full, else oldest store drains.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            automatic bit full = (q.size() == DEPTH);
            automatic bit lw   = bus.ld_valid && !full;
            if (!lw && q.size() > 0) void'(q.pop_front());
            if (bus.st_valid && !full) q.push_back('{a: bus.st_addr, d: bus.st_data});
        end
    end

    always @(negedge clk) begin
        if (running) begin
            automatic int            n     = q.size();
            automatic bit            full  = (n == DEPTH);
            automatic logic          ewren = 1'b0;
            automatic logic [AW-1:0] eaddr = '0;
            automatic logic [DW-1:0] edin  = '0;
            automatic logic          ehit  = 1'b0;
            automatic logic [DW-1:0] efwd  = '0;
            if (bus.ld_valid && !full) begin
                eaddr = bus.ld_addr;
            end else if (n > 0) begin
                ewren = 1'b1;
                eaddr = q[0].a;
                edin  = q[0].d;
            end
            if (bus.ld_valid) begin
                for (int i = n - 1; i >= 0; i--) begin
                    if (q[i].a == bus.ld_addr) begin
                        ehit = 1'b1;
                        efwd = q[i].d;
                        break;
                    end
                end
            end
            chk("st_ready", 64'(bus.st_ready), 64'(!full));
            chk("ld_stall", 64'(bus.ld_stall), 64'(full));
            chk("empty", 64'(bus.empty), 64'(n == 0));
            chk("count", 64'(bus.count), 64'(n));
            chk("dm_wren", 64'(bus.dm_wren), 64'(ewren));
            chk("dm_addr", 64'(bus.dm_addr), 64'(eaddr));
            chk("dm_din", 64'(bus.dm_din), 64'(edin));
            chk("ld_hit", 64'(bus.ld_hit), 64'(ehit));
            chk("ld_fwd_data", 64'(bus.ld_fwd_data), 64'(efwd));
        end
    end

    initial begin
        reset = 1'b1;
        set_st(1'b0, '0, '0);
        set_ld(1'b0, '0);
        tick();
        tick();
        running = 1'b1;

        // Post-reset state
        reset = 1'b0;
        #1;
        chk("rst_st_ready", 64'(bus.st_ready), 64'd1);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_dm_wren", 64'(bus.dm_wren), 64'd0);
        chk("rst_ld_hit", 64'(bus.ld_hit), 64'd0);
        chk("rst_ld_stall", 64'(bus.ld_stall), 64'd0);

        // Single store drains the following cycle
        set_st(1'b1, 7'd5, 32'd20);
        tick();
        set_st(1'b0, '0, '0);
        #1;
        chk("s1_wren", 64'(bus.dm_wren), 64'd1);
        chk("s1_addr", 64'(bus.dm_addr), 64'd5);
        chk("s1_din", 64'(bus.dm_din), 64'd20);
        tick();
        #1;
        chk("s1_empty", 64'(bus.empty), 64'd1);

        // Two stores to one address; forwarding picks the youngest
        set_ld(1'b1, 7'd7);
        set_st(1'b1, 7'd7, 32'd15);
        tick();
        set_st(1'b1, 7'd7, 32'd30);
        #1;
        chk("s2_fwd_old", 64'(bus.ld_fwd_data), 64'd15);
        tick();
        set_st(1'b0, '0, '0);
        #1;
        chk("s2_hit", 64'(bus.ld_hit), 64'd1);
        chk("s2_fwd_young", 64'(bus.ld_fwd_data), 64'd30);
        chk("s2_count", 64'(bus.count), 64'd2);
        set_ld(1'b0, '0);
        #1;
        chk("s2_din0", 64'(bus.dm_din), 64'd15);
        tick();
        #1;
        chk("s2_din1", 64'(bus.dm_din), 64'd30);
        tick();
        #1;
        chk("s2_empty", 64'(bus.empty), 64'd1);

        // Loads hold the port until full; full refuses a push while draining
        set_ld(1'b1, 7'd3);
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, AW'(10 + i), DW'(100 + i));
            #1;
            chk("s3_no_drain", 64'(bus.dm_wren), 64'd0);
            tick();
        end
        set_st(1'b1, 7'd99, 32'd999);
        #1;
        chk("s3_count4", 64'(bus.count), 64'd4);
        chk("s3_stall", 64'(bus.ld_stall), 64'd1);
        chk("s3_wren", 64'(bus.dm_wren), 64'd1);
        chk("s3_addr", 64'(bus.dm_addr), 64'd10);
        chk("s3_not_ready", 64'(bus.st_ready), 64'd0);
        tick();
        set_st(1'b0, '0, '0);
        #1;
        chk("s3_count3", 64'(bus.count), 64'd3);
        chk("s3_ready", 64'(bus.st_ready), 64'd1);
        set_ld(1'b0, '0);
        #1;
        wq.delete();
        for (int i = 0; i < 20 && !bus.empty; i++) begin
            if (bus.dm_wren) wq.push_back(bus.dm_addr);
            tick();
        end
        chk("s3_drained", 64'(bus.empty), 64'd1);
        chk("s3_nwrites", 64'(wq.size()), 64'd3);
        for (int i = 0; i < 3 && i < wq.size(); i++) chk("s3_order", 64'(wq[i]), 64'(11 + i));

        // Reset during the first drain discards everything
        set_ld(1'b1, 7'd3);
        for (int i = 0; i < 3; i++) begin
            set_st(1'b1, AW'(20 + i), DW'(i));
            tick();
        end
        set_st(1'b0, '0, '0);
        set_ld(1'b0, '0);
        #1;
        chk("s4_draining", 64'(bus.dm_wren), 64'd1);
        chk("s4_addr", 64'(bus.dm_addr), 64'd20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("s4_count", 64'(bus.count), 64'd0);
        chk("s4_empty", 64'(bus.empty), 64'd1);
        chk("s4_wren", 64'(bus.dm_wren), 64'd0);
        tick();
        #1;
        chk("s4_quiet", 64'(bus.dm_wren), 64'd0);

        // Six stores with interleaved drains wrap the pointers
        wq.delete();
        for (int i = 1; i <= 6; i++) begin
            set_st(1'b1, AW'(i), DW'(i * 3));
            set_ld(i[0], 7'h40);
            #1;
            if (bus.dm_wren) wq.push_back(bus.dm_addr);
            tick();
        end
        set_st(1'b0, '0, '0);
        set_ld(1'b0, '0);
        #1;
        for (int i = 0; i < 20 && !bus.empty; i++) begin
            if (bus.dm_wren) wq.push_back(bus.dm_addr);
            tick();
        end
        chk("s5_drained", 64'(bus.empty), 64'd1);
        chk("s5_nwrites", 64'(wq.size()), 64'd6);
        for (int i = 0; i < 6 && i < wq.size(); i++) chk("s5_order", 64'(wq[i]), 64'(i + 1));

        // Randomized traffic on a small address range to provoke forwarding hits
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_st($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), $urandom);
            set_ld($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)));
            tick();
        end

        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
